// File: rtl/rapid_pkg.sv
// Shared types and default geometry for the direct-mapped instruction cache.
package rapid_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REFILL  = 2'd1,
    RESPOND = 2'd2
  } icache_state_t;

  localparam int DEF_LINES = 16;
  localparam int DEF_WORDS = 4;

endpackage

// File: rtl/icache_data_ram.sv
// Instruction data storage: one write port, one registered read port, no reset.
module icache_data_ram #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [AW-1:0]          waddr,
  input  logic signed [XLEN-1:0] wdata,
  input  logic [AW-1:0]          raddr,
  output logic signed [XLEN-1:0] rdata
);

  logic signed [XLEN-1:0] mem [DEPTH];

  // Write a refill beat and register the read word every cycle.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache with burst line refill.
// Optional build macro ICACHE_PERF_CNT_EN adds saturating hit/miss counters.
module icache_dm
  import rapid_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int LINES = DEF_LINES,
  parameter int WORDS = DEF_WORDS
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_req,
  input  logic [XLEN-1:0]        i_address,
  input  logic                   i_flush,
  output logic signed [XLEN-1:0] o_data,
  output logic                   o_done,
  output logic                   o_busy,
  output logic                   o_mem_req,
  output logic [XLEN-1:0]        o_mem_addr,
  input  logic                   i_mem_valid,
  input  logic [XLEN-1:0]        i_mem_data
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]            o_hit_cnt,
  output logic [31:0]            o_miss_cnt
`endif
);

  localparam int OFF_W  = $clog2(WORDS);
  localparam int IDX_W  = $clog2(LINES);
  localparam int TAG_W  = XLEN - 2 - OFF_W - IDX_W;
  localparam int RAM_AW = IDX_W + OFF_W;

  icache_state_t state, state_nxt;

  logic [LINES-1:0]       valid;
  logic [TAG_W-1:0]       tags [LINES];
  logic [XLEN-3:0]        req_addr;
  logic [OFF_W-1:0]       beat_cnt;
  logic                   flush_pend;
  logic                   hit_vld_p1;
  logic signed [XLEN-1:0] fill_word;
  logic signed [XLEN-1:0] ram_rdata;

  logic [IDX_W-1:0] in_idx, lat_idx;
  logic [OFF_W-1:0] in_off, lat_off;
  logic [TAG_W-1:0] in_tag, lat_tag;
  logic             hit, accept, last_beat, ram_we;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^i_address[1:0];

  assign in_off  = i_address[2 +: OFF_W];
  assign in_idx  = i_address[2+OFF_W +: IDX_W];
  assign in_tag  = i_address[XLEN-1 -: TAG_W];
  assign lat_off = req_addr[0 +: OFF_W];
  assign lat_idx = req_addr[OFF_W +: IDX_W];
  assign lat_tag = req_addr[XLEN-3 -: TAG_W];

  // Flush in IDLE wins over a same-cycle request; the request is dropped.
  assign hit       = valid[in_idx] && (tags[in_idx] == in_tag);
  assign accept    = (state == IDLE) && i_req && !i_flush;
  assign last_beat = (state == REFILL) && i_mem_valid && (beat_cnt == OFF_W'(WORDS - 1));
  assign ram_we    = (state == REFILL) && i_mem_valid;

  icache_data_ram #(
    .XLEN  (XLEN),
    .DEPTH (LINES * WORDS),
    .AW    (RAM_AW)
  ) u_data_ram (
    .clk   (i_clk),
    .we    (ram_we),
    .waddr ({lat_idx, beat_cnt}),
    .wdata (i_mem_data),
    .raddr ({in_idx, in_off}),
    .rdata (ram_rdata)
  );

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && !hit) state_nxt = REFILL;
      REFILL:  if (last_beat)      state_nxt = RESPOND;
      RESPOND:                     state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  // Control state: FSM, valid bits, beat counter, deferred flush, hit pipeline.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= IDLE;
      valid      <= '0;
      beat_cnt   <= '0;
      flush_pend <= 1'b0;
      hit_vld_p1 <= 1'b0;
    end else begin
      state      <= state_nxt;
      hit_vld_p1 <= accept && hit;
      case (state)
        IDLE: begin
          if (i_flush) valid <= '0;
        end
        REFILL: begin
          if (i_flush) flush_pend <= 1'b1;
          // Counter wraps naturally so the beat address stays inside the line.
          if (i_mem_valid) beat_cnt <= beat_cnt + OFF_W'(1);
          if (last_beat && !flush_pend && !i_flush) valid[lat_idx] <= 1'b1;
        end
        RESPOND: begin
          if (flush_pend || i_flush) valid <= '0;
          flush_pend <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Datapath state: latched miss address, tag write, critical-word capture.
  always_ff @(posedge i_clk) begin
    if (accept && !hit) req_addr <= i_address[XLEN-1:2];
    if (last_beat)      tags[lat_idx] <= lat_tag;
    if (ram_we && (beat_cnt == lat_off)) fill_word <= i_mem_data;
  end

  assign o_busy     = (state != IDLE);
  assign o_mem_req  = (state == REFILL);
  assign o_mem_addr = (state == REFILL) ? {req_addr[XLEN-3:OFF_W], beat_cnt, 2'b00} : '0;
  assign o_done     = hit_vld_p1 || (state == RESPOND);
  assign o_data     = (state == RESPOND) ? fill_word :
                      hit_vld_p1         ? ram_rdata : '0;

`ifdef ICACHE_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  // Hit/miss counters, saturating, cleared only by reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_hit_cnt  <= '0;
      o_miss_cnt <= '0;
    end else if (accept) begin
      if (hit) o_hit_cnt  <= sat_inc(o_hit_cnt);
      else     o_miss_cnt <= sat_inc(o_miss_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm (default geometry: 16 lines x 4 words).
module tb_icache_dm;

  logic               i_clk = 1'b0;
  logic               i_reset;
  logic               i_req;
  logic [31:0]        i_address;
  logic               i_flush;
  logic signed [31:0] o_data;
  logic               o_done;
  logic               o_busy;
  logic               o_mem_req;
  logic [31:0]        o_mem_addr;
  logic               i_mem_valid;
  logic [31:0]        i_mem_data;

  int checks = 0;
  int errors = 0;

  icache_dm dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_req       (i_req),
    .i_address   (i_address),
    .i_flush     (i_flush),
    .o_data      (o_data),
    .o_done      (o_done),
    .o_busy      (o_busy),
    .o_mem_req   (o_mem_req),
    .o_mem_addr  (o_mem_addr),
    .i_mem_valid (i_mem_valid),
    .i_mem_data  (i_mem_data)
  );

  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue a request for one cycle; caller checks the cycle after.
  task automatic request(input logic [31:0] addr);
    i_req     = 1'b1;
    i_address = addr;
    step();
    i_req     = 1'b0;
  endtask

  // Serve a 4-beat refill starting at base; optionally pulse flush on one beat.
  task automatic refill(input string tag, input logic [31:0] base,
                        input logic [31:0] d0, input int flush_beat);
    for (int k = 0; k < 4; k++) begin
      check({tag, "_req"},  {31'd0, o_mem_req}, 32'd1);
      check({tag, "_addr"}, o_mem_addr, base + 32'(4 * k));
      i_mem_valid = 1'b1;
      i_mem_data  = d0 + 32'(k);
      i_flush     = (k == flush_beat);
      step();
    end
    i_mem_valid = 1'b0;
    i_flush     = 1'b0;
  endtask

  task automatic expect_respond(input string tag, input logic [31:0] word);
    check({tag, "_done"},  {31'd0, o_done}, 32'd1);
    check({tag, "_data"},  o_data, word);
    check({tag, "_mreq"},  {31'd0, o_mem_req}, 32'd0);
    step();
    check({tag, "_idle"},  {31'd0, o_busy}, 32'd0);
    check({tag, "_ndone"}, {31'd0, o_done}, 32'd0);
  endtask

  initial begin
    i_reset = 1'b1; i_req = 1'b0; i_address = '0; i_flush = 1'b0;
    i_mem_valid = 1'b0; i_mem_data = '0;
    step(); step();
    check("rst_done",  {31'd0, o_done},    32'd0);
    check("rst_busy",  {31'd0, o_busy},    32'd0);
    check("rst_mreq",  {31'd0, o_mem_req}, 32'd0);
    check("rst_maddr", o_mem_addr,         32'd0);
    check("rst_data",  o_data,             32'd0);
    i_reset = 1'b0;
    step();

    // Cold miss at 0x100, critical word is offset 0.
    request(32'h100);
    check("m1_busy", {31'd0, o_busy}, 32'd1);
    refill("m1", 32'h100, 32'hA0, -1);
    expect_respond("m1", 32'hA0);

    // Hits, back to back, 1-cycle latency.
    i_req = 1'b1; i_address = 32'h108;
    step();
    check("h1_done", {31'd0, o_done},    32'd1);
    check("h1_data", o_data,             32'hA2);
    check("h1_mreq", {31'd0, o_mem_req}, 32'd0);
    i_address = 32'h104;
    step();
    check("h2_done", {31'd0, o_done}, 32'd1);
    check("h2_data", o_data,          32'hA1);
    i_req = 1'b0;
    step();
    check("h2_end",  {31'd0, o_done}, 32'd0);

    // Conflict miss on index 0 evicts the 0x100 line.
    request(32'h1100);
    refill("m2", 32'h1100, 32'hB0, -1);
    expect_respond("m2", 32'hB0);
    request(32'h104);
    refill("m3", 32'h100, 32'hC0, -1);
    expect_respond("m3", 32'hC1);

    // Flush with a same-cycle request in IDLE: request dropped.
    i_flush = 1'b1;
    request(32'h104);
    i_flush = 1'b0;
    check("fl_done", {31'd0, o_done}, 32'd0);
    check("fl_busy", {31'd0, o_busy}, 32'd0);
    request(32'h10C);
    refill("m4", 32'h100, 32'hD0, -1);
    expect_respond("m4", 32'hD3);

    // Flush during refill: data returned, line left invalid.
    request(32'h108);
    check("h3_data", o_data, 32'hD2);
    request(32'h2200);
    refill("m5", 32'h2200, 32'hE0, 1);
    expect_respond("m5", 32'hE0);
    request(32'h2200);
    refill("m6", 32'h2200, 32'hF0, -1);
    expect_respond("m6", 32'hF0);

    // Reset at beat 2 of a refill abandons the burst.
    request(32'h3300);
    for (int k = 0; k < 2; k++) begin
      i_mem_valid = 1'b1; i_mem_data = 32'h55 + 32'(k);
      step();
    end
    i_mem_valid = 1'b0;
    check("rb_addr", o_mem_addr, 32'h3308);
    i_reset = 1'b1;
    step();
    check("rb_mreq", {31'd0, o_mem_req}, 32'd0);
    check("rb_done", {31'd0, o_done},    32'd0);
    i_reset = 1'b0;
    step();
    check("rb_done2", {31'd0, o_done}, 32'd0);
    request(32'h3300);
    refill("m7", 32'h3300, 32'h70, -1);
    expect_respond("m7", 32'h70);
    request(32'h2204);
    refill("m8", 32'h2200, 32'h80, -1);
    expect_respond("m8", 32'h81);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/icache_dm.md
ICACHE_DM -- requirements
Module: icache_dm

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width in bits.
REQ-002 SHALL have parameter LINES, default 16, number of cache lines (power of two, >=2).
REQ-003 SHALL have parameter WORDS, default 4, XLEN-bit words per line (power of two, >=2).
REQ-004 SHALL have port i_clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port i_reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port i_req  input  1  fetch request, sampled only in IDLE.
REQ-007 SHALL have port i_address  input  XLEN  byte address of the fetch; bits [1:0] ignored.
REQ-008 SHALL have port i_flush  input  1  invalidate-all request.
REQ-009 SHALL have port o_data  output  XLEN (signed)  fetched instruction word, valid when o_done=1.
REQ-010 SHALL have port o_done  output  1  one-cycle pulse marking fetch completion.
REQ-011 SHALL have port o_busy  output  1  high in any state other than IDLE.
REQ-012 SHALL have port o_mem_req  output  1  refill beat request to memory.
REQ-013 SHALL have port o_mem_addr  output  XLEN  word-aligned refill beat address.
REQ-014 SHALL have port i_mem_valid  input  1  memory beat accepted; i_mem_data valid.
REQ-015 SHALL have port i_mem_data  input  XLEN  refill beat data.

Function
REQ-016 SHALL be direct-mapped: offset = addr[2+:log2(WORDS)], index = next log2(LINES) bits, tag = remaining upper bits.
REQ-017 SHALL use FSM states IDLE, REFILL, RESPOND.
REQ-018 IDLE, i_req=1, valid[index] and tag match: SHALL register o_data and pulse o_done next cycle (1-cycle hit latency), staying in IDLE.
REQ-019 IDLE, i_req=1, miss: SHALL latch address, go REFILL, assert o_mem_req next cycle with o_mem_addr = line base.
REQ-020 REFILL: SHALL hold o_mem_req high; each i_mem_valid writes i_mem_data to word beat_cnt and advances o_mem_addr by 4.
REQ-021 On beat WORDS-1 SHALL drop o_mem_req, write tag, set valid[index], go RESPOND.
REQ-022 RESPOND: SHALL output the latched-offset word with o_done=1 for one cycle, then go IDLE.
REQ-023 i_mem_valid outside REFILL SHALL be ignored.
REQ-024 i_flush in IDLE SHALL clear all valid bits in one cycle and take priority over a same-cycle i_req (request dropped, no o_done).
REQ-025 i_flush during REFILL/RESPOND SHALL be latched; burst completes, line not marked valid, data still returned, all valids cleared on return to IDLE.
REQ-026 Back-to-back hits SHALL sustain one completion per cycle; i_req is ignored while o_busy=1.
REQ-027 beat_cnt SHALL wrap from WORDS-1 to 0; o_mem_addr SHALL never cross the line boundary.

Reset
REQ-028 i_reset SHALL force IDLE, clear all valid bits, beat_cnt, pending flush; o_done=0, o_data=0, o_busy=0, o_mem_req=0, o_mem_addr=0.
REQ-029 Reset mid-REFILL SHALL abandon the burst with no line marked valid and no o_done.
REQ-030 Data/tag arrays SHALL NOT require reset.

Configuration
REQ-031 With ICACHE_PERF_CNT_EN defined SHALL add outputs o_hit_cnt and o_miss_cnt (32 bits each), incremented per hit/miss, saturating at all-ones, cleared by reset only.
REQ-032 Without ICACHE_PERF_CNT_EN those ports and counters SHALL not exist; behaviour otherwise identical.

Structure
REQ-033 rapid_pkg SHALL hold the icache_state_t enum (IDLE, REFILL, RESPOND) and default LINES/WORDS constants.
REQ-034 Data storage SHALL be a sub-module icache_data_ram (LINES*WORDS x XLEN, one write port, one read port, synchronous).

Verification
REQ-035 Reset, req 0x100 -> o_mem_req beats 0x100,0x104,0x108,0x10C; feed 0xA0..0xA3 -> o_done with o_data=0xA0.
REQ-036 Then req 0x108 -> hit, o_done next cycle, o_data=0xA2, o_mem_req stays 0.
REQ-037 Req 0x1100 (same index, other tag, LINES=16) -> refill; then 0x100 -> miss again (eviction).
REQ-038 i_flush with i_req same cycle in IDLE -> no o_done; next req 0x100 -> miss.
REQ-039 i_flush mid-REFILL -> data returned, following req same address -> miss.
REQ-040 i_reset asserted at beat 2 of refill -> o_mem_req=0 next cycle, no o_done, next req same address -> miss.
